conv1_maxpool2x2: RTL and testbench

- Downstream neighbour of the conv layer-1 stage.
- Consumes the four per-filter feature-map rows read back from the conv1 result SRAMs: 24 pixels x 8 bit per channel, one row per cycle.
- Performs 2x2 stride-2 max pooling on all four channels in parallel.
- Emits one 12-pixel pooled row per channel for every two input rows, so a 24x24 map becomes a 12x12 map for the next layer.

---
 rtl/conv1_maxpool2x2.sv | 136 +++++++++++++
 tb/tb_conv1_maxpool2x2.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/conv1_maxpool2x2.sv
// 2x2 stride-2 max pooling over four conv1 feature-map channels, one input row per beat.
// Optional CONV1_POOL_RELU_EN: pixels are signed and clamped at zero before the compare.
module conv1_maxpool2x2 #(
  parameter int unsigned COLS = 24,
  parameter int unsigned ROWS = 24,
  parameter int unsigned DW   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   din_vald,
  input  logic                   din_sof,
  input  logic [COLS*DW-1:0]     din_0,
  input  logic [COLS*DW-1:0]     din_1,
  input  logic [COLS*DW-1:0]     din_2,
  input  logic [COLS*DW-1:0]     din_3,
  output logic                   dout_vald,
  output logic [COLS/2*DW-1:0]   dout_0,
  output logic [COLS/2*DW-1:0]   dout_1,
  output logic [COLS/2*DW-1:0]   dout_2,
  output logic [COLS/2*DW-1:0]   dout_3,
  output logic [3:0]             dout_row,
  output logic                   frame_done
);

  localparam int unsigned IW = COLS * DW;
  localparam int unsigned OC = COLS / 2;
  localparam int unsigned OW = OC * DW;
  localparam int unsigned CW = $clog2(ROWS);

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          row_cnt_q, row_cnt_d;
  logic [3:0][IW-1:0]     buf_q, buf_d;
  logic [3:0][OW-1:0]     dout_q, dout_d;
  logic                   dout_vald_q, dout_vald_d;
  logic [3:0]             dout_row_q, dout_row_d;
  logic                   frame_done_q, frame_done_d;

  logic [3:0][IW-1:0]     din_c;
  logic [3:0][OW-1:0]     pool_c;
  logic                   last_c;

  assign din_c  = {din_3, din_2, din_1, din_0};
  assign last_c = (row_cnt_q == CW'(ROWS - 1));

  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] p);
`ifdef CONV1_POOL_RELU_EN
    clamp = p[DW-1] ? '0 : p;
`else
    clamp = p;
`endif
  endfunction

  // After clamping every pixel is non-negative, so an unsigned compare serves both modes.
  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    max2 = (a > b) ? a : b;
  endfunction

  // Pooled row from the stored (even) row and the current (odd) row.
  always_comb begin
    pool_c = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < int'(OC); k++) begin
        pool_c[c][OW-1-DW*k -: DW] = max2(
          max2(clamp(buf_q[c][IW-1-DW*(2*k)   -: DW]), clamp(buf_q[c][IW-1-DW*(2*k+1) -: DW])),
          max2(clamp(din_c[c][IW-1-DW*(2*k)   -: DW]), clamp(din_c[c][IW-1-DW*(2*k+1) -: DW])));
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EVEN;
      row_cnt_q    <= '0;
      buf_q        <= '0;
      dout_q       <= '0;
      dout_vald_q  <= 1'b0;
      dout_row_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      buf_q        <= buf_d;
      dout_q       <= dout_d;
      dout_vald_q  <= dout_vald_d;
      dout_row_q   <= dout_row_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next state: sof always restarts at row 0, so the following beat is odd.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    if (din_vald) begin
      if (din_sof) begin
        state_d   = ODD;
        row_cnt_d = CW'(1);
      end else if (state_q == EVEN) begin
        state_d   = ODD;
        row_cnt_d = row_cnt_q + CW'(1);
      end else begin
        state_d   = EVEN;
        row_cnt_d = last_c ? '0 : row_cnt_q + CW'(1);
      end
    end
  end

  // Outputs and row buffers.
  always_comb begin
    buf_d        = buf_q;
    dout_d       = dout_q;
    dout_vald_d  = 1'b0;
    dout_row_d   = dout_row_q;
    frame_done_d = 1'b0;
    if (din_vald && (din_sof || state_q == EVEN)) begin
      buf_d = din_c;
    end else if (din_vald) begin
      dout_d       = pool_c;
      dout_vald_d  = 1'b1;
      dout_row_d   = 4'(row_cnt_q >> 1);
      frame_done_d = last_c;
    end
  end

  assign dout_vald  = dout_vald_q;
  assign dout_0     = dout_q[0];
  assign dout_1     = dout_q[1];
  assign dout_2     = dout_q[2];
  assign dout_3     = dout_q[3];
  assign dout_row   = dout_row_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv1_maxpool2x2.sv
// Directed bench for conv1_maxpool2x2: reset, single pair, full frame, gaps, resync, boundaries.
module tb_conv1_maxpool2x2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         din_vald, din_sof;
  logic [191:0] din_0, din_1, din_2, din_3;
  logic         dout_vald, frame_done;
  logic [95:0]  dout_0, dout_1, dout_2, dout_3;
  logic [3:0]   dout_row;

  int n_vec = 0;
  int n_err = 0;

  conv1_maxpool2x2 dut (
    .clk(clk), .rst_n(rst_n),
    .din_vald(din_vald), .din_sof(din_sof),
    .din_0(din_0), .din_1(din_1), .din_2(din_2), .din_3(din_3),
    .dout_vald(dout_vald),
    .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2), .dout_3(dout_3),
    .dout_row(dout_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row where pixel j = base + j (mod 256).
  function automatic logic [191:0] ramp(input int base);
    logic [191:0] r;
    r = '0;
    for (int j = 0; j < 24; j++) r[191-8*j -: 8] = 8'(base + j);
    return r;
  endfunction

  // Pooled ramp pair whose odd row starts at b: pixel k = b + 2k + 1.
  function automatic logic [95:0] ramp_pool(input int b);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < 12; k++) r[95-8*k -: 8] = 8'(b + 2*k + 1);
    return r;
  endfunction

  // Row whose pixels alternate between a (even j) and b (odd j), or with period 4 via sel.
  function automatic logic [191:0] pat(input logic [7:0] a, input logic [7:0] b, input int mod4hit);
    logic [191:0] r;
    r = '0;
    for (int j = 0; j < 24; j++) begin
      if (mod4hit >= 0) r[191-8*j -: 8] = ((j % 4) == mod4hit) ? a : b;
      else              r[191-8*j -: 8] = ((j % 2) == 0) ? a : b;
    end
    return r;
  endfunction

  function automatic logic [95:0] fill96(input logic [7:0] v);
    return {12{v}};
  endfunction

  task automatic beat(input logic v, input logic s,
                      input logic [191:0] r0, input logic [191:0] r1,
                      input logic [191:0] r2, input logic [191:0] r3);
    din_vald = v; din_sof = s;
    din_0 = r0; din_1 = r1; din_2 = r2; din_3 = r3;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  logic [95:0] exp_pair;
  logic [7:0]  e_ff, e_80, e_mix;

  initial begin
    rst_n = 1'b0;
    din_vald = 1'b0; din_sof = 1'b0;
    din_0 = '0; din_1 = '0; din_2 = '0; din_3 = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_vald", 192'(dout_vald), 192'(0));
    check("rst_row",  192'(dout_row), 192'(0));
    check("rst_dout0", 192'(dout_0), 192'(0));
    rst_n = 1'b1;

    // Single pair on channel 0: row0 = j, row1 = 23 - j.
    beat(1'b1, 1'b1, ramp(0), '0, '0, '0);
    check("pair_no_early_vald", 192'(dout_vald), 192'(0));
    begin
      logic [191:0] rev;
      rev = '0;
      for (int j = 0; j < 24; j++) rev[191-8*j -: 8] = 8'(23 - j);
      beat(1'b1, 1'b0, rev, '0, '0, '0);
    end
    exp_pair = 96'h17_15_13_11_0f_0d_0d_0f_11_13_15_17;
    check("pair_vald", 192'(dout_vald), 192'(1));
    check("pair_dout0", 192'(dout_0), 192'(exp_pair));
    check("pair_dout1", 192'(dout_1), 192'(0));
    check("pair_row", 192'(dout_row), 192'(0));
    check("pair_fd", 192'(frame_done), 192'(0));
    idle();
    check("pair_vald_drop", 192'(dout_vald), 192'(0));
    check("pair_hold", 192'(dout_0), 192'(exp_pair));

    // Full frame back to back; channel c offset by 16c.
    for (int r = 0; r < 24; r++) begin
      beat(1'b1, (r == 0), ramp(r), ramp(r + 16), ramp(r + 32), ramp(r + 48));
      if (r % 2 == 1) begin
        check("ff_vald", 192'(dout_vald), 192'(1));
        check("ff_row", 192'(dout_row), 192'(r / 2));
        check("ff_fd", 192'(frame_done), 192'(r == 23));
        check("ff_d0", 192'(dout_0), 192'(ramp_pool(r)));
        check("ff_d1", 192'(dout_1), 192'(ramp_pool(r + 16)));
        check("ff_d2", 192'(dout_2), 192'(ramp_pool(r + 32)));
        check("ff_d3", 192'(dout_3), 192'(ramp_pool(r + 48)));
      end else begin
        check("ff_vald_even", 192'(dout_vald), 192'(0));
        check("ff_fd_even", 192'(frame_done), 192'(0));
      end
    end
    idle();
    check("ff_fd_after", 192'(frame_done), 192'(0));

    // Gaps: three idle cycles between row 0 and row 1 of the new frame.
    beat(1'b1, 1'b0, ramp(0), ramp(16), ramp(32), ramp(48));
    for (int i = 0; i < 3; i++) begin
      idle();
      check("gap_no_vald", 192'(dout_vald), 192'(0));
    end
    beat(1'b1, 1'b0, ramp(1), ramp(17), ramp(33), ramp(49));
    check("gap_vald", 192'(dout_vald), 192'(1));
    check("gap_row", 192'(dout_row), 192'(0));
    check("gap_d0", 192'(dout_0), 192'(ramp_pool(1)));
    check("gap_d3", 192'(dout_3), 192'(ramp_pool(49)));

    // Resync: sof arrives while a stored 0xFE row waits in ODD.
    beat(1'b1, 1'b0, {24{8'hfe}}, {24{8'hfe}}, {24{8'hfe}}, {24{8'hfe}});
    check("rs_no_vald0", 192'(dout_vald), 192'(0));
    beat(1'b1, 1'b1, ramp(0), ramp(16), ramp(32), ramp(48));
    check("rs_discard", 192'(dout_vald), 192'(0));
    check("rs_discard_fd", 192'(frame_done), 192'(0));
    beat(1'b1, 1'b0, ramp(1), ramp(17), ramp(33), ramp(49));
    check("rs_vald", 192'(dout_vald), 192'(1));
    check("rs_row", 192'(dout_row), 192'(0));
    check("rs_d0", 192'(dout_0), 192'(ramp_pool(1)));
    check("rs_d2", 192'(dout_2), 192'(ramp_pool(33)));

    // Boundary values.
`ifdef CONV1_POOL_RELU_EN
    e_ff = 8'h00; e_80 = 8'h7f; e_mix = 8'h00;
`else
    e_ff = 8'hff; e_80 = 8'h80; e_mix = 8'hff;
`endif
    beat(1'b1, 1'b0, pat(8'hff, 8'h00, 0), {24{8'h80}}, '0, pat(8'h80, 8'hff, -1));
    beat(1'b1, 1'b0, pat(8'hff, 8'h00, 3), {24{8'h7f}}, '0, pat(8'hff, 8'h80, -1));
    check("bnd_vald", 192'(dout_vald), 192'(1));
    check("bnd_row", 192'(dout_row), 192'(1));
    check("bnd_ff", 192'(dout_0), 192'(fill96(e_ff)));
    check("bnd_80", 192'(dout_1), 192'(fill96(e_80)));
    check("bnd_zero", 192'(dout_2), 192'(0));
    check("bnd_mix", 192'(dout_3), 192'(fill96(e_mix)));

    // Reset mid-frame with a row stored and outputs non-zero.
    beat(1'b1, 1'b0, {24{8'hfe}}, '0, '0, '0);
    rst_n = 1'b0;
    #1;
    check("mrst_d1", 192'(dout_1), 192'(0));
    check("mrst_row", 192'(dout_row), 192'(0));
    check("mrst_vald", 192'(dout_vald), 192'(0));
    idle();
    rst_n = 1'b1;
    beat(1'b1, 1'b1, ramp(0), ramp(16), ramp(32), ramp(48));
    check("mrst_no_vald", 192'(dout_vald), 192'(0));
    beat(1'b1, 1'b0, ramp(1), ramp(17), ramp(33), ramp(49));
    check("mrst_vald2", 192'(dout_vald), 192'(1));
    check("mrst_row2", 192'(dout_row), 192'(0));
    check("mrst_d0", 192'(dout_0), 192'(ramp_pool(1)));
    check("mrst_d1b", 192'(dout_1), 192'(ramp_pool(17)));
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
